// File: rtl/avr_serial_rx.sv
// ============================================================================
// avr_serial_rx
// ----------------------------------------------------------------------------
// UART receiver for the AVR -> FPGA serial link (8 data bits, no parity,
// 1 stop bit, LSB first). The line is oversampled at the system clock. The
// start bit is re-checked at half a bit period, and every following bit is
// sampled in the middle of its bit cell. A good frame is presented on rx_data
// with a one-cycle new_rx_data strobe. A frame whose stop bit is low raises a
// one-cycle frame_err strobe instead. The receiver then waits for the line to
// return high, so that a held-low break is not decoded as a stream of 0x00
// bytes.
//
// Parameters:
//   CLK_PER_BIT  system clocks per bit; even, >= 4 (default 50 MHz / 500 kbaud)
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous, active-high reset
//   rx           serial line from the AVR, idle high, asynchronous to clk
//   rx_data      last correctly received byte
//   new_rx_data  one-cycle strobe: rx_data was updated this cycle
//   frame_err    one-cycle strobe: stop bit was sampled low
// ============================================================================
module avr_serial_rx #(
    parameter int CLK_PER_BIT = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       new_rx_data,
    output logic       frame_err
);

    localparam int HALF_BIT = CLK_PER_BIT / 2;
    localparam int CTR_W    = (CLK_PER_BIT > 2) ? $clog2(CLK_PER_BIT) : 1;

    localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(CLK_PER_BIT - 1);
    localparam logic [CTR_W-1:0] CTR_HALF = CTR_W'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t           state;
    logic [1:0]       sync_q;
    logic             rx_s;
    logic [CTR_W-1:0] ctr;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;

    // NOTE: both synchronizer flops reset to the idle level (1), so leaving
    // reset never looks like a falling edge on the line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling the
            // pre-edge values, which is what makes this a two-stage chain.
            sync_q <= {sync_q[0], rx};
        end
    end

    assign rx_s = sync_q[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            ctr         <= '0;
            bit_idx     <= 3'd0;
            shreg       <= 8'h00;
            rx_data     <= 8'h00;
            new_rx_data <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            // NOTE: the strobes default low here and are raised only in the
            // branch that completes a frame, so each lasts exactly one cycle.
            new_rx_data <= 1'b0;
            frame_err   <= 1'b0;

            unique case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        state <= S_START;
                        ctr   <= '0;
                    end
                end

                S_START: begin
                    if (ctr == CTR_HALF) begin
                        if (!rx_s) begin
                            // Start bit still low at mid-bit: genuine frame.
                            state   <= S_DATA;
                            ctr     <= '0;
                            bit_idx <= 3'd0;
                        end else begin
                            // Line came back high: treat the low pulse as a glitch.
                            state <= S_IDLE;
                        end
                    end else begin
                        ctr <= ctr + CTR_W'(1);
                    end
                end

                S_DATA: begin
                    if (ctr == CTR_LAST) begin
                        ctr   <= '0;
                        shreg <= {rx_s, shreg[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        ctr <= ctr + CTR_W'(1);
                    end
                end

                S_STOP: begin
                    if (ctr == CTR_LAST) begin
                        ctr <= '0;
                        if (rx_s) begin
                            rx_data     <= shreg;
                            new_rx_data <= 1'b1;
                            state       <= S_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= S_BREAK;
                        end
                    end else begin
                        ctr <= ctr + CTR_W'(1);
                    end
                end

                S_BREAK: begin
                    // Hold off until the line is released; a new start bit
                    // can only be recognised from IDLE.
                    if (rx_s) begin
                        state <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_avr_serial_rx.sv
// ============================================================================
// tb_avr_serial_rx
// ----------------------------------------------------------------------------
// Directed bench for avr_serial_rx. One instance runs at CLK_PER_BIT=16 for
// the bulk of the scenarios; a second instance runs at the default rate and
// receives a frame sent about 4% fast (96 clocks per bit). A negedge monitor
// records strobe times and values; the main initial block compares them
// against hand-computed expectations.
// ============================================================================
module tb_avr_serial_rx;

    localparam int C = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx16 = 1'b1;
    logic       rx100 = 1'b1;
    logic [7:0] rx_data16, rx_data100;
    logic       nrx16, nrx100, ferr16, ferr100;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // monitor state for the CLK_PER_BIT=16 instance
    int         n_str  = 0;
    int         n_ferr = 0;
    int         n_viol = 0;
    int         ferr_cyc = 0;
    int         str_cyc [16];
    logic [7:0] str_val [16];
    logic       prev_n = 1'b0;
    logic       prev_f = 1'b0;

    // monitor state for the default-rate instance
    int         n100      = 0;
    int         n100_ferr = 0;
    logic [7:0] val100    = 8'h00;

    avr_serial_rx #(.CLK_PER_BIT(C)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx16),
        .rx_data    (rx_data16),
        .new_rx_data(nrx16),
        .frame_err  (ferr16)
    );

    avr_serial_rx dut100 (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx100),
        .rx_data    (rx_data100),
        .new_rx_data(nrx100),
        .frame_err  (ferr100)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (nrx16) begin
            if (n_str < 16) begin
                str_cyc[n_str] = cyc;
                str_val[n_str] = rx_data16;
            end
            n_str++;
        end
        if (ferr16) begin
            ferr_cyc = cyc;
            n_ferr++;
        end
        if ((nrx16 && ferr16) || (nrx16 && prev_n) || (ferr16 && prev_f))
            n_viol++;
        prev_n = nrx16;
        prev_f = ferr16;
        if (nrx100) begin
            val100 = rx_data100;
            n100++;
        end
        if (ferr100) n100_ferr++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Always called and returns at "#1 after a rising edge".
    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_line(input bit line100, input logic v);
        if (line100) rx100 = v;
        else         rx16  = v;
    endtask

    // Start bit, 8 data bits LSB first, stop bit; each held cpb cycles.
    // No trailing gap, so consecutive calls give back-to-back frames.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input int cpb, input bit line100);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            set_line(line100, bits[i]);
            wait_cyc(cpb);
        end
    endtask

    int t0;

    initial begin
        // ---------------- reset state ----------------
        wait_cyc(4);
        check("rst_rx_data", {24'h0, rx_data16}, 32'h00);
        check("rst_new_rx_data", {31'h0, nrx16}, 32'h0);
        check("rst_frame_err", {31'h0, ferr16}, 32'h0);
        rst = 1'b0;
        wait_cyc(5);

        // ---------------- good frame 0xA5 ----------------
        t0 = cyc;
        send_frame(8'hA5, 1'b1, C, 1'b0);
        wait_cyc(5);
        check("good_count", n_str, 1);
        check("good_value", {24'h0, str_val[0]}, 32'hA5);
        check("good_latency", str_cyc[0] - t0, 155);
        check("good_no_ferr", n_ferr, 0);
        check("good_rx_data_hold", {24'h0, rx_data16}, 32'hA5);

        // ---------------- back-to-back 0x00, 0xFF ----------------
        t0 = cyc;
        send_frame(8'h00, 1'b1, C, 1'b0);
        send_frame(8'hFF, 1'b1, C, 1'b0);
        wait_cyc(20);
        check("b2b_count", n_str, 3);
        check("b2b_first", {24'h0, str_val[1]}, 32'h00);
        check("b2b_second", {24'h0, str_val[2]}, 32'hFF);
        check("b2b_first_latency", str_cyc[1] - t0, 155);
        check("b2b_spacing", str_cyc[2] - str_cyc[1], 160);

        // ---------------- glitch rejection ----------------
        rx16 = 1'b0;
        wait_cyc(4);
        rx16 = 1'b1;
        wait_cyc(30);
        check("glitch_no_strobe", n_str, 3);
        check("glitch_no_ferr", n_ferr, 0);
        send_frame(8'h3C, 1'b1, C, 1'b0);
        wait_cyc(10);
        check("after_glitch_count", n_str, 4);
        check("after_glitch_value", {24'h0, str_val[3]}, 32'h3C);

        // ---------------- framing error / break ----------------
        t0 = cyc;
        send_frame(8'h55, 1'b0, C, 1'b0);   // line left low
        wait_cyc(300);
        check("ferr_count", n_ferr, 1);
        check("ferr_latency", ferr_cyc - t0, 155);
        check("break_no_strobe", n_str, 4);
        check("break_rx_data_kept", {24'h0, rx_data16}, 32'h3C);
        rx16 = 1'b1;
        wait_cyc(20);
        send_frame(8'h81, 1'b1, C, 1'b0);
        wait_cyc(10);
        check("post_break_count", n_str, 5);
        check("post_break_value", {24'h0, str_val[4]}, 32'h81);
        check("post_break_ferr", n_ferr, 1);

        // ---------------- reset mid-frame (0xF0, reset in bit 3) ----------------
        rx16 = 1'b0;                        // start
        wait_cyc(C);
        for (int i = 0; i < 3; i++) begin   // bits 0..2 of 0xF0 are 0
            rx16 = 1'b0;
            wait_cyc(C);
        end
        rx16 = 1'b0;                        // bit 3
        wait_cyc(4);
        rst = 1'b1;
        #1;
        check("midrst_rx_data", {24'h0, rx_data16}, 32'h00);
        check("midrst_new_rx_data", {31'h0, nrx16}, 32'h0);
        check("midrst_frame_err", {31'h0, ferr16}, 32'h0);
        wait_cyc(C - 4);
        rx16 = 1'b1;                        // bit 4 of 0xF0 is 1
        wait_cyc(2);
        rst = 1'b0;
        wait_cyc(C - 2);
        for (int i = 5; i < 9; i++) begin   // bits 5..7 high, then stop high
            rx16 = 1'b1;
            wait_cyc(C);
        end
        wait_cyc(20);
        check("aborted_no_strobe", n_str, 5);
        check("aborted_no_ferr", n_ferr, 1);
        check("aborted_rx_data", {24'h0, rx_data16}, 32'h00);
        send_frame(8'h12, 1'b1, C, 1'b0);
        wait_cyc(10);
        check("post_rst_count", n_str, 6);
        check("post_rst_value", {24'h0, str_val[5]}, 32'h12);

        // ---------------- default rate, +4% baud ----------------
        send_frame(8'hC3, 1'b1, 96, 1'b1);
        wait_cyc(100);
        check("fast_count", n100, 1);
        check("fast_value", {24'h0, val100}, 32'hC3);
        check("fast_no_ferr", n100_ferr, 0);

        // ---------------- strobe shape over the whole run ----------------
        check("strobe_shape_violations", n_viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
